load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter ADDR_LEN, 32, byte-address width; SHALL be a multiple of 8 and at least 8.
REQ-002 Parameter DATA_LEN, 32, data word width; only 32 is supported.
REQ-003 clk  input  1  single clock; all state SHALL change on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 req_valid  input  1  core request present.
REQ-006 req_ready  output  1  unit can accept a request.
REQ-007 req_we  input  1  1 = store, 0 = load.
REQ-008 req_size  input  2  00 byte, 01 halfword, 10 word, 11 reserved.
REQ-009 req_unsigned  input  1  load zero-extends when 1 and sign-extends when 0.
REQ-010 req_addr  input  ADDR_LEN  byte address.
REQ-011 req_wdata  input  DATA_LEN  store data, right-justified.
REQ-012 resp_valid  output  1  response present.
REQ-013 resp_ready  input  1  core accepts the response.
REQ-014 resp_rdata  output  DATA_LEN  extended load data; 0 for stores and errors.
REQ-015 resp_err  output  1  misaligned address or reserved size.
REQ-016 dmem_addr  output  ADDR_LEN  word index = req_addr >> 2, zero-filled in the upper bits.
REQ-017 dmem_wdata  output  DATA_LEN  word written to the data memory.
REQ-018 dmem_we  output  1  data-memory write enable.
REQ-019 dmem_rdata  input  DATA_LEN  data-memory read data; valid the cycle after the address is presented with dmem_we=0.

Function
REQ-020 FSM states SHALL be IDLE, READ, MERGE, WRITE and RESP; the unit SHALL have one request outstanding at most.
REQ-021 req_ready SHALL be 1 only in IDLE with reset low; a request is accepted on a rising edge where req_valid and req_ready are both 1.
REQ-022 On acceptance the unit SHALL register addr, size, we, unsigned and wdata; later req_* changes SHALL have no effect.
REQ-023 Error cases: size 11, halfword with addr[0]=1, or word with addr[1:0]!=00.
  - Transitions: IDLE->RESP with resp_err=1 and resp_rdata=0.
  - The data memory SHALL NOT be accessed.
REQ-024 Word store: IDLE->WRITE.
  - In WRITE: dmem_we=1 and dmem_wdata=req_wdata.
  - Transition: WRITE->RESP.
REQ-025 Load or sub-word store: IDLE->READ.
  - In READ: dmem_we=0 and dmem_addr=word index.
  - Transition: READ->MERGE.
REQ-026 Sub-word store, MERGE cycle:
  - dmem_we=1.
  - dmem_wdata = dmem_rdata with only the selected lane(s) replaced by the low byte or halfword of wdata.
  - Transition: MERGE->RESP.
REQ-027 Load, MERGE cycle:
  - Extract byte lane addr[1:0] or halfword lane addr[1], little-endian.
  - Extend the extracted data per req_unsigned into resp_rdata.
  - Transition: MERGE->RESP.
REQ-028 Word load SHALL return dmem_rdata unchanged; req_unsigned is ignored.
REQ-029 In RESP, resp_valid SHALL be 1 and resp_rdata and resp_err SHALL be held stable until resp_ready=1; the transition is then RESP->IDLE.
REQ-030 resp_ready SHALL be ignored outside RESP.
REQ-031 Latency, from the acceptance edge to the first cycle with resp_valid=1:
  - error: 1 cycle
  - word store: 2 cycles
  - load or sub-word store: 3 cycles.
REQ-032 Best-case throughput: a new request SHALL be accepted on the first edge after resp_valid is handshaked.
REQ-033 dmem_we SHALL be 1 only in WRITE, or in MERGE for a sub-word store; it SHALL be 1 for exactly one cycle per store and never for loads or errors.
REQ-034 dmem_addr and dmem_wdata SHALL be driven from registered state and SHALL NOT depend combinationally on req_*.

Reset
REQ-035 Asserting reset SHALL immediately force state=IDLE.
REQ-036 While reset is asserted, the outputs SHALL be: req_ready=0, resp_valid=0, resp_err=0, resp_rdata=0, dmem_we=0, dmem_addr=0, dmem_wdata=0.
REQ-037 Reset asserted during READ, MERGE, WRITE or RESP SHALL abandon the request with no memory write after reset assertion and no response; req_ready SHALL be 1 in the first cycle after reset deasserts.

Verification
REQ-038 Word store then load: store 0x11223344 at addr 0x08, then load word from 0x08.
  - Memory word 2 is written.
  - Load returns 0x11223344, resp_err=0, latency 3.
REQ-039 Byte store merge: word 2 = 0x11223344; store byte 0xAB at addr 0x09.
  - One read, then one write of 0x1122AB44.
  - Response latency 3.
REQ-040 Sign/zero extension: word 2 = 0x80FF7F01.
  - Signed byte load at 0x0A returns 0xFFFFFFFF.
  - Unsigned byte load at 0x0A returns 0x000000FF.
  - Signed halfword load at 0x0A returns 0xFFFF80FF.
  - Unsigned halfword load at 0x08 returns 0x00007F01.
REQ-041 Errors: word load at 0x06, halfword store at 0x03, size 11 at 0x00.
  - Each gives resp_err=1, resp_rdata=0, latency 1.
  - dmem_we stays 0 throughout.
REQ-042 Backpressure: resp_ready held 0 for 5 cycles in RESP.
  - resp_valid, resp_rdata and resp_err are stable for all 5 cycles.
  - req_ready=0 throughout.
  - The request offered on the handshake edge is not accepted.
REQ-043 Reset mid-operation: assert reset in READ of a byte store.
  - dmem_we never pulses.
  - Memory is unchanged.
  - resp_valid=0.
  - req_ready=1 one cycle after release.

Source files
------------

// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding load/store engine with sub-word merge and sign/zero extension
module load_store_unit #(
  parameter int ADDR_LEN = 32,
  parameter int DATA_LEN = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [1:0]          req_size,
  input  logic                req_unsigned,
  input  logic [ADDR_LEN-1:0] req_addr,
  input  logic [DATA_LEN-1:0] req_wdata,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [DATA_LEN-1:0] resp_rdata,
  output logic                resp_err,
  output logic [ADDR_LEN-1:0] dmem_addr,
  output logic [DATA_LEN-1:0] dmem_wdata,
  output logic                dmem_we,
  input  logic [DATA_LEN-1:0] dmem_rdata
);
  typedef enum logic [2:0] {IDLE, READ, MERGE, WRITE, RESP} state_t;
  state_t state, state_n;
  logic [ADDR_LEN-1:0] addr_q;
  logic [1:0] size_q;
  logic we_q, uns_q, err_q;
  logic [DATA_LEN-1:0] wdata_q, rdata_q;
  logic req_err, accept, sub_store;
  logic [4:0] sh;
  logic [DATA_LEN-1:0] mask, lane, load_data, merged;
  assign req_err = req_size == 2'b11 || (req_size == 2'b01 && req_addr[0]) ||
                   (req_size == 2'b10 && req_addr[1:0] != 2'b00);
  assign req_ready = state == IDLE && !reset;
  assign accept = req_valid && req_ready;
  // Bit offset of the addressed lane; word accesses are aligned so it is 0 for them
  assign sh = size_q == 2'b00 ? {addr_q[1:0], 3'b000} : {addr_q[1], 4'b0000};
  assign mask = (size_q == 2'b00 ? 32'h0000_00ff : 32'h0000_ffff) << sh;
  assign lane = dmem_rdata >> sh;
  assign load_data = size_q == 2'b10 ? dmem_rdata :
                     size_q == 2'b01 ? {{16{~uns_q & lane[15]}}, lane[15:0]} :
                                       {{24{~uns_q & lane[7]}}, lane[7:0]};
  assign merged = (dmem_rdata & ~mask) | ((wdata_q << sh) & mask);
  assign sub_store = state == MERGE && we_q;
  assign resp_valid = state == RESP;
  assign resp_rdata = rdata_q;
  assign resp_err = err_q;
  assign dmem_addr = {2'b00, addr_q[ADDR_LEN-1:2]};
  assign dmem_we = state == WRITE || sub_store;
  assign dmem_wdata = state == WRITE ? wdata_q : sub_store ? merged : '0;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:         if (accept) state_n = req_err ? RESP : (req_we && req_size == 2'b10) ? WRITE : READ;
      READ:         state_n = MERGE;
      MERGE, WRITE: state_n = RESP;
      RESP:         state_n = resp_ready ? IDLE : RESP;
      default:      state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      addr_q  <= '0;
      size_q  <= '0;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        addr_q  <= req_addr;
        size_q  <= req_size;
        we_q    <= req_we;
        uns_q   <= req_unsigned;
        wdata_q <= req_wdata;
        err_q   <= req_err;
        rdata_q <= '0;
      end
      if (state == MERGE && !we_q) rdata_q <= load_data;
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed scoreboard bench for load_store_unit with a behavioural data memory
module tb_load_store_unit;
  logic clk = 1'b0, reset = 1'b1;
  logic req_valid = 1'b0, req_we = 1'b0, req_unsigned = 1'b0, resp_ready = 1'b0;
  logic [1:0] req_size = 2'b00;
  logic [31:0] req_addr = '0, req_wdata = '0, dmem_rdata = '0;
  logic req_ready, resp_valid, resp_err, dmem_we;
  logic [31:0] resp_rdata, dmem_addr, dmem_wdata;
  logic [31:0] mem [16];
  int n_assert = 0, n_fail = 0, we_cnt = 0;
  typedef struct {logic err; logic [31:0] rdata; int lat;} exp_t;
  exp_t sb[$];
  load_store_unit dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_we(dmem_we), .dmem_rdata(dmem_rdata)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (dmem_we) mem[dmem_addr[3:0]] <= dmem_wdata;
    dmem_rdata <= mem[dmem_addr[3:0]];
  end
  always @(negedge clk) if (dmem_we) we_cnt++;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic drive(input logic we, input logic [1:0] size, input logic uns, input logic [31:0] addr, input logic [31:0] wdata);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns; req_addr = addr; req_wdata = wdata;
    check("req_ready_before_accept", {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_we = ~we; req_size = $urandom_range(0, 3); req_addr = $urandom; req_wdata = $urandom;
  endtask
  task automatic wait_resp(input string tag);
    exp_t e;
    int l = 1;
    while (!resp_valid && l < 20) begin
      @(posedge clk);
      #1;
      l++;
    end
    e = sb.pop_front();
    check({tag, "_valid"}, {31'd0, resp_valid}, 32'd1);
    check({tag, "_err"}, {31'd0, resp_err}, {31'd0, e.err});
    check({tag, "_rdata"}, resp_rdata, e.rdata);
    check({tag, "_latency"}, l, e.lat);
  endtask
  task automatic run(input string tag, input logic we, input logic [1:0] size, input logic uns,
                     input logic [31:0] addr, input logic [31:0] wdata,
                     input logic err, input logic [31:0] rdata, input int lat, input int pulses);
    int w0 = we_cnt;
    sb.push_back('{err, rdata, lat});
    drive(we, size, uns, addr, wdata);
    wait_resp(tag);
    @(negedge clk);
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    check({tag, "_ready_after"}, {31'd0, req_ready}, 32'd1);
    check({tag, "_we_pulses"}, we_cnt - w0, pulses);
  endtask
  initial begin
    int w0;
    for (int i = 0; i < 16; i++) mem[i] = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", {31'd0, req_ready}, 32'd0);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_dmem_we", {31'd0, dmem_we}, 32'd0);
    check("rst_dmem_addr", dmem_addr, 32'd0);
    reset = 1'b0;
    run("st_word", 1, 2'b10, 0, 32'h08, 32'h1122_3344, 0, 32'h0, 2, 1);
    check("mem2_word", mem[2], 32'h1122_3344);
    run("ld_word", 0, 2'b10, 1, 32'h08, 32'h0, 0, 32'h1122_3344, 3, 0);
    run("st_byte", 1, 2'b00, 0, 32'h09, 32'hFFFF_FFAB, 0, 32'h0, 3, 1);
    check("mem2_merge", mem[2], 32'h1122_AB44);
    run("st_word2", 1, 2'b10, 0, 32'h08, 32'h80FF_7F01, 0, 32'h0, 2, 1);
    run("ld_sb_0a", 0, 2'b00, 0, 32'h0A, 32'h0, 0, 32'hFFFF_FFFF, 3, 0);
    run("ld_ub_0a", 0, 2'b00, 1, 32'h0A, 32'h0, 0, 32'h0000_00FF, 3, 0);
    run("ld_sh_0a", 0, 2'b01, 0, 32'h0A, 32'h0, 0, 32'hFFFF_80FF, 3, 0);
    run("ld_uh_08", 0, 2'b01, 1, 32'h08, 32'h0, 0, 32'h0000_7F01, 3, 0);
    run("ld_sb_09", 0, 2'b00, 0, 32'h09, 32'h0, 0, 32'h0000_007F, 3, 0);
    run("st_half", 1, 2'b01, 0, 32'h0E, 32'h1234_BEEF, 0, 32'h0, 3, 1);
    check("mem3_half", mem[3], 32'hBEEF_0000);
    run("err_ld_w06", 0, 2'b10, 0, 32'h06, 32'h0, 1, 32'h0, 1, 0);
    run("err_st_h03", 1, 2'b01, 0, 32'h03, 32'hFFFF_FFFF, 1, 32'h0, 1, 0);
    run("err_size3", 0, 2'b11, 0, 32'h00, 32'h0, 1, 32'h0, 1, 0);
    // Backpressure: hold the response for five cycles, then offer a store on the handshake edge
    w0 = we_cnt;
    sb.push_back('{1'b0, 32'h80FF_7F01, 3});
    drive(0, 2'b10, 0, 32'h08, 32'h0);
    wait_resp("bp");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_hold_valid", {31'd0, resp_valid}, 32'd1);
      check("bp_hold_rdata", resp_rdata, 32'h80FF_7F01);
      check("bp_hold_err", {31'd0, resp_err}, 32'd0);
      check("bp_hold_req_ready", {31'd0, req_ready}, 32'd0);
    end
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_addr = 32'h0C; req_wdata = 32'hDEAD_BEEF;
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0; req_valid = 1'b0;
    check("bp_idle_ready", {31'd0, req_ready}, 32'd1);
    repeat (4) @(negedge clk);
    check("bp_no_resp", {31'd0, resp_valid}, 32'd0);
    check("bp_mem3", mem[3], 32'hBEEF_0000);
    check("bp_no_write", we_cnt - w0, 0);
    // Reset while the byte store is in READ
    w0 = we_cnt;
    drive(1, 2'b00, 0, 32'h09, 32'h0000_0055);
    reset = 1'b1;
    #1;
    check("mid_rst_req_ready", {31'd0, req_ready}, 32'd0);
    check("mid_rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("mid_rst_resp_err", {31'd0, resp_err}, 32'd0);
    check("mid_rst_resp_rdata", resp_rdata, 32'd0);
    check("mid_rst_dmem_we", {31'd0, dmem_we}, 32'd0);
    check("mid_rst_dmem_addr", dmem_addr, 32'd0);
    check("mid_rst_dmem_wdata", dmem_wdata, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("post_rst_ready", {31'd0, req_ready}, 32'd1);
    repeat (3) @(negedge clk);
    check("post_rst_no_resp", {31'd0, resp_valid}, 32'd0);
    check("post_rst_no_write", we_cnt - w0, 0);
    check("post_rst_mem2", mem[2], 32'h80FF_7F01);
    run("ld_after_rst", 0, 2'b10, 0, 32'h08, 32'h0, 0, 32'h80FF_7F01, 3, 0);
    check("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
